// File: rtl/cv32e40p_pkg.sv
// Shared types for the cv32e40p APU sharing logic.
package cv32e40p_pkg;

    // IDLE: no selection held; LOCKED: winner held until the APU accepts it
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } apu_arb_state_e;

    // Width of a requester index, never narrower than one bit
    function automatic int apuIdWidth(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/cv32e40p_apu_id_fifo.sv
// In-order FIFO of requester IDs for requests accepted by the APU but not yet answered.
module cv32e40p_apu_id_fifo
    import cv32e40p_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wrPtr;
    logic [PW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign full_o   = (r_count == CW'(DEPTH));
    assign empty_o  = (r_count == '0);
    assign head_o   = r_mem[r_rdPtr];
    assign w_doPush = push_i && !full_o;
    assign w_doPop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= data_i;
                r_wrPtr        <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin arbiter sharing one APU between NREQ requesters, with in-order response routing.
module cv32e40p_apu_arbiter
    import cv32e40p_pkg::*;
#(
    parameter int NREQ          = 2,
    parameter int APU_NARGS_CPU = 3,
    parameter int APU_WOP_CPU   = 6,
    parameter int DEPTH         = 4
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [NREQ-1:0]                             req_i,
    input  logic [NREQ-1:0][APU_NARGS_CPU-1:0][31:0]    operands_i,
    input  logic [NREQ-1:0][APU_WOP_CPU-1:0]            op_i,
    output logic [NREQ-1:0]                             gnt_o,
    output logic [NREQ-1:0]                             rvalid_o,
    output logic [31:0]                                 result_o,
    output logic                                        apu_req_o,
    output logic [APU_NARGS_CPU-1:0][31:0]              apu_operands_o,
    output logic [APU_WOP_CPU-1:0]                      apu_op_o,
    input  logic                                        apu_gnt_i,
    input  logic                                        apu_rvalid_i,
    input  logic [31:0]                                 apu_result_i,
    output logic                                        resp_err_o
);

    localparam int IDW = apuIdWidth(NREQ);

    apu_arb_state_e r_state;
    apu_arb_state_e w_nextState;
    logic [IDW-1:0] r_lastGrant;
    logic [IDW-1:0] r_lockIdx;
    logic           r_respErr;
    logic [IDW-1:0] w_rrWinner;
    logic [IDW-1:0] w_sel;
    logic           w_reqRaw;
    logic           w_apuReq;
    logic           w_handshake;
    logic           w_pop;
    logic           w_fifoFull;
    logic           w_fifoEmpty;
    logic [IDW-1:0] w_head;

    // First active requester scanning upward from the one after the last grant
    function automatic logic [IDW-1:0] rrSelect(input logic [NREQ-1:0] req,
                                                input logic [IDW-1:0]  last);
        logic [IDW-1:0] res;
        logic           found;
        int             idx;
        res   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && req[idx]) begin
                res   = IDW'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign w_rrWinner = rrSelect(req_i, r_lastGrant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // New arbitration only when the ID FIFO can take the result; a lock ignores later arrivals
    always_comb begin
        w_nextState = r_state;
        w_reqRaw    = 1'b0;
        w_sel       = r_lockIdx;
        case (r_state)
            IDLE: begin
                if ((|req_i) && !w_fifoFull) begin
                    w_reqRaw = 1'b1;
                    w_sel    = w_rrWinner;
                    if (!apu_gnt_i) begin
                        w_nextState = LOCKED;
                    end
                end
            end
            LOCKED: begin
                w_reqRaw = 1'b1;
                w_sel    = r_lockIdx;
                if (apu_gnt_i) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign w_apuReq    = w_reqRaw && rst_n;
    assign w_handshake = w_apuReq && apu_gnt_i;
    assign w_pop       = apu_rvalid_i && !w_fifoEmpty && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lastGrant <= IDW'(NREQ - 1);
            r_lockIdx   <= '0;
        end else begin
            if (w_handshake) begin
                r_lastGrant <= w_sel;
            end
            if ((r_state == IDLE) && (w_nextState == LOCKED)) begin
                r_lockIdx <= w_sel;
            end
        end
    end

    // A response with nothing outstanding is a protocol error that stays visible until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_respErr <= 1'b0;
        end else if (apu_rvalid_i && w_fifoEmpty) begin
            r_respErr <= 1'b1;
        end
    end

    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        if (w_handshake) begin
            gnt_o[w_sel] = 1'b1;
        end
        if (w_pop) begin
            rvalid_o[w_head] = 1'b1;
        end
    end

    assign apu_req_o      = w_apuReq;
    assign apu_operands_o = w_apuReq ? operands_i[w_sel] : '0;
    assign apu_op_o       = w_apuReq ? op_i[w_sel] : '0;
    assign result_o       = apu_result_i;
    assign resp_err_o     = r_respErr;

    cv32e40p_apu_id_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (IDW)
    ) u_idFifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_handshake),
        .data_i  (w_sel),
        .pop_i   (w_pop),
        .full_o  (w_fifoFull),
        .empty_o (w_fifoEmpty),
        .head_o  (w_head)
    );

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Self-checking bench: queue-based reference model checked every cycle plus directed literal checks.
module tb_cv32e40p_apu_arbiter;

    localparam int NREQ  = 2;
    localparam int NARGS = 3;
    localparam int WOP   = 6;
    localparam int DEPTH = 4;

    logic                             clk;
    logic                             rst_n;
    logic [NREQ-1:0]                  req_i;
    logic [NREQ-1:0][NARGS-1:0][31:0] operands_i;
    logic [NREQ-1:0][WOP-1:0]         op_i;
    logic [NREQ-1:0]                  gnt_o;
    logic [NREQ-1:0]                  rvalid_o;
    logic [31:0]                      result_o;
    logic                             apu_req_o;
    logic [NARGS-1:0][31:0]           apu_operands_o;
    logic [WOP-1:0]                   apu_op_o;
    logic                             apu_gnt_i;
    logic                             apu_rvalid_i;
    logic [31:0]                      apu_result_i;
    logic                             resp_err_o;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model state: outstanding IDs in order, round-robin pointer, pending lock
    int mQ[$];
    int mLast;
    bit mLocked;
    int mLockIdx;
    bit mErr;

    cv32e40p_apu_arbiter #(
        .NREQ          (NREQ),
        .APU_NARGS_CPU (NARGS),
        .APU_WOP_CPU   (WOP),
        .DEPTH         (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_i          (req_i),
        .operands_i     (operands_i),
        .op_i           (op_i),
        .gnt_o          (gnt_o),
        .rvalid_o       (rvalid_o),
        .result_o       (result_o),
        .apu_req_o      (apu_req_o),
        .apu_operands_o (apu_operands_o),
        .apu_op_o       (apu_op_o),
        .apu_gnt_i      (apu_gnt_i),
        .apu_rvalid_i   (apu_rvalid_i),
        .apu_result_i   (apu_result_i),
        .resp_err_o     (resp_err_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic gnt, input logic rv,
                                 input logic [31:0] res);
        @(posedge clk);
        #1;
        req_i        = req;
        apu_gnt_i    = gnt;
        apu_rvalid_i = rv;
        apu_result_i = res;
        @(negedge clk);
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_err_low", resp_err_o, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_err_after", resp_err_o, 1'b0);
    endtask

    // Model compare: derive expected outputs from the arbitration rules each falling edge
    initial begin
        int       eSel;
        bit       eReq;
        bit       eHs;
        bit       ePop;
        logic [1:0] eGnt;
        logic [1:0] eRv;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                checkOutput("mdl_rst_gnt", gnt_o, 2'b00);
                checkOutput("mdl_rst_rvalid", rvalid_o, 2'b00);
                checkOutput("mdl_rst_apureq", apu_req_o, 1'b0);
                checkOutput("mdl_rst_op", apu_op_o, '0);
                checkOutput("mdl_rst_operands", apu_operands_o, '0);
                checkOutput("mdl_rst_err", resp_err_o, 1'b0);
                mQ.delete();
                mLast    = NREQ - 1;
                mLocked  = 1'b0;
                mLockIdx = 0;
                mErr     = 1'b0;
            end else begin
                eReq = 1'b0;
                eSel = 0;
                if (mLocked) begin
                    eReq = 1'b1;
                    eSel = mLockIdx;
                end else if (req_i != '0 && mQ.size() < DEPTH) begin
                    eReq = 1'b1;
                    for (int k = NREQ; k >= 1; k--) begin
                        if (req_i[(mLast + k) % NREQ]) eSel = (mLast + k) % NREQ;
                    end
                end
                eHs  = eReq && apu_gnt_i;
                ePop = apu_rvalid_i && (mQ.size() > 0);
                eGnt = eHs ? 2'(1 << eSel) : 2'b00;
                eRv  = ePop ? 2'(1 << mQ[0]) : 2'b00;
                checkOutput("mdl_gnt", gnt_o, eGnt);
                checkOutput("mdl_rvalid", rvalid_o, eRv);
                checkOutput("mdl_apureq", apu_req_o, eReq);
                checkOutput("mdl_result", result_o, apu_result_i);
                checkOutput("mdl_err", resp_err_o, mErr);
                if (eReq) begin
                    checkOutput("mdl_op", apu_op_o, op_i[eSel]);
                    checkOutput("mdl_operands", apu_operands_o, operands_i[eSel]);
                end
                if (apu_rvalid_i && mQ.size() == 0) mErr = 1'b1;
                if (ePop) void'(mQ.pop_front());
                if (eHs) begin
                    mQ.push_back(eSel);
                    mLast   = eSel;
                    mLocked = 1'b0;
                end else if (eReq) begin
                    mLocked  = 1'b1;
                    mLockIdx = eSel;
                end
            end
        end
    end

    initial begin
        logic [1:0]  expRv[4];
        logic [31:0] res4[4];
        clk          = 1'b0;
        rst_n        = 1'b0;
        req_i        = '0;
        apu_gnt_i    = 1'b0;
        apu_rvalid_i = 1'b0;
        apu_result_i = '0;
        op_i[0]      = 6'h11;
        op_i[1]      = 6'h22;
        for (int r = 0; r < NREQ; r++) begin
            for (int a = 0; a < NARGS; a++) begin
                operands_i[r][a] = 32'h1000 * (r + 1) + a;
            end
        end

        @(negedge clk);
        checkOutput("reset_apureq", apu_req_o, 1'b0);
        checkOutput("reset_gnt", gnt_o, 2'b00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);

        // Two requesters, APU always ready: grants alternate, responses follow in order
        applyStimulus(2'b11, 1'b1, 1'b0, 32'h0);
        checkOutput("alt_gnt0", gnt_o, 2'b01);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b11, 1'b1, 1'b1, 32'h100 + i);
            checkOutput("alt_gnt", gnt_o, (i % 2 == 0) ? 2'b10 : 2'b01);
            checkOutput("alt_rvalid", rvalid_o, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        applyStimulus(2'b00, 1'b1, 1'b1, 32'h0);
        checkOutput("alt_drain", rvalid_o, 2'b10);

        // Locked requester 1 survives a stall while requester 0 arrives
        applyStimulus(2'b10, 1'b0, 1'b0, 32'h0);
        checkOutput("lock_op_c1", apu_op_o, 6'h22);
        checkOutput("lock_gnt_c1", gnt_o, 2'b00);
        applyStimulus(2'b11, 1'b0, 1'b0, 32'h0);
        checkOutput("lock_op_c2", apu_op_o, 6'h22);
        applyStimulus(2'b11, 1'b0, 1'b0, 32'h0);
        checkOutput("lock_op_c3", apu_op_o, 6'h22);
        checkOutput("lock_opnd_c3", apu_operands_o[0], 32'h2000);
        applyStimulus(2'b11, 1'b1, 1'b0, 32'h0);
        checkOutput("lock_gnt", gnt_o, 2'b10);
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h0);
        checkOutput("lock_next_gnt", gnt_o, 2'b01);
        applyStimulus(2'b00, 1'b0, 1'b1, 32'h7);
        checkOutput("lock_rv0", rvalid_o, 2'b10);
        applyStimulus(2'b00, 1'b0, 1'b1, 32'h8);
        checkOutput("lock_rv1", rvalid_o, 2'b01);

        // Single requester fills the FIFO; a pop does not bypass into a same-cycle grant
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(2'b01, 1'b1, 1'b0, 32'h0);
            checkOutput("fill_gnt", gnt_o, 2'b01);
        end
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h0);
        checkOutput("full_apureq", apu_req_o, 1'b0);
        checkOutput("full_gnt", gnt_o, 2'b00);
        applyStimulus(2'b01, 1'b1, 1'b1, 32'h55);
        checkOutput("full_pop_apureq", apu_req_o, 1'b0);
        checkOutput("full_pop_rvalid", rvalid_o, 2'b01);
        checkOutput("full_pop_result", result_o, 32'h55);
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h0);
        checkOutput("after_pop_gnt", gnt_o, 2'b01);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(2'b00, 1'b0, 1'b1, 32'h60 + i);
            checkOutput("full_drain", rvalid_o, 2'b01);
        end

        // Grants 0,1,1,0 answered in order
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h0);
        checkOutput("ord_g0", gnt_o, 2'b01);
        applyStimulus(2'b10, 1'b1, 1'b0, 32'h0);
        checkOutput("ord_g1", gnt_o, 2'b10);
        applyStimulus(2'b10, 1'b1, 1'b0, 32'h0);
        checkOutput("ord_g2", gnt_o, 2'b10);
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h0);
        checkOutput("ord_g3", gnt_o, 2'b01);
        expRv = '{2'b01, 2'b10, 2'b10, 2'b01};
        res4  = '{32'hA, 32'hB, 32'hC, 32'hD};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b00, 1'b0, 1'b1, res4[i]);
            checkOutput("ord_rvalid", rvalid_o, expRv[i]);
            checkOutput("ord_result", result_o, res4[i]);
        end

        // Push and pop together with two outstanding keeps the order
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h0);
        applyStimulus(2'b10, 1'b1, 1'b0, 32'h0);
        applyStimulus(2'b01, 1'b1, 1'b1, 32'h1);
        checkOutput("pp_gnt", gnt_o, 2'b01);
        checkOutput("pp_rvalid", rvalid_o, 2'b01);
        applyStimulus(2'b00, 1'b0, 1'b1, 32'h2);
        checkOutput("pp_rv_oldest", rvalid_o, 2'b10);
        applyStimulus(2'b00, 1'b0, 1'b1, 32'h3);
        checkOutput("pp_rv_last", rvalid_o, 2'b01);

        // Stray response sets the sticky error
        applyStimulus(2'b00, 1'b0, 1'b1, 32'h99);
        checkOutput("stray_rvalid", rvalid_o, 2'b00);
        checkOutput("stray_result", result_o, 32'h99);
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
        checkOutput("stray_err", resp_err_o, 1'b1);
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
        checkOutput("stray_err_sticky", resp_err_o, 1'b1);
        pulseReset();

        // Reset discards an outstanding ID; its late response is an error
        applyStimulus(2'b01, 1'b1, 1'b0, 32'h0);
        checkOutput("pre_rst_gnt", gnt_o, 2'b01);
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
        pulseReset();
        applyStimulus(2'b00, 1'b0, 1'b1, 32'h5);
        checkOutput("late_rvalid", rvalid_o, 2'b00);
        applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
        checkOutput("late_err", resp_err_o, 1'b1);

        @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
